// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller: one WIDTH-bit ripple adder
// is reused over WIDTH cycles to build a 2*WIDTH-bit unsigned product.

module mult_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module mult_ripple_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mult_fa u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Carry-out is kept as the top sum bit so the shift never loses it.
    assign sum = {c[WIDTH], s};
endmodule

module mult_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    input  logic               ack,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] hi;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             last;

    assign addend = mplier[0] ? mcand : '0;
    assign last   = (cnt == CW'(WIDTH - 1));

    mult_ripple_add #(.WIDTH(WIDTH)) u_add (
        .x   (hi),
        .y   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            hi      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        hi     <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // Right shift of {carry, hi, mplier}; product bits fill mplier from the top.
                    {hi, mplier} <= {sum, mplier[WIDTH-1:1]};
                    cnt          <= cnt + 1'b1;
                    if (last) product <= {sum, mplier[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end
endmodule
